relu_layer_argmax: RTL and testbench

- Final classification stage. Sits directly downstream of the last fully-connected layer's ReLU neuron nodes.
- Captures one frame of NUM_CLASSES unsigned 8-bit neuron outputs, scans it sequentially (one lane per cycle) and reports the winning class index and score.
- Uses a valid/ready handshake on both sides so the ECG front end can stall on it.

---
 rtl/relu_layer_argmax.sv | 107 ++++++++++
 tb/tb_relu_layer_argmax.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/relu_layer_argmax.sv
// Final classification stage: captures one frame of ReLU neuron outputs, scans it one
// lane per cycle and presents the argmax class and score under a valid/ready handshake.
module relu_layer_argmax #(
  parameter int NUM_CLASSES = 4,
  parameter int DW          = 8,
  parameter int IDXW        = 2,
  parameter int CNTW        = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_CLASSES*DW-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [IDXW-1:0]           out_class,
  output logic [DW-1:0]             out_score,
  output logic                      out_all_zero,
  output logic [CNTW-1:0]           frame_cnt
);

  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

  localparam logic [IDXW-1:0] LAST_LANE = IDXW'(NUM_CLASSES - 1);
  localparam logic [IDXW-1:0] FIRST_PTR = (NUM_CLASSES > 1) ? IDXW'(1) : '0;

  state_t          state, state_nxt;
  logic [DW-1:0]   lanes [NUM_CLASSES];
  logic [DW-1:0]   best_score;
  logic [IDXW-1:0] best_idx;
  logic [IDXW-1:0] ptr;
  logic            accept;
  logic            last_lane;
  logic            better;
  logic [DW-1:0]   scan_score;
  logic [IDXW-1:0] scan_idx;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every output of this block is given a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = (NUM_CLASSES == 1) ? HOLD : SCAN;
      end
      SCAN: begin
        if (last_lane) state_nxt = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Strict compare keeps the lowest index on ties.
  assign accept     = (state == IDLE) && in_valid;
  assign last_lane  = (ptr == LAST_LANE);
  assign better     = lanes[ptr] > best_score;
  assign scan_score = better ? lanes[ptr] : best_score;
  assign scan_idx   = better ? ptr : best_idx;

  // NOTE: the capture registers are plain flops (not RAM), so they are reset along with the rest.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_CLASSES; k++) lanes[k] <= '0;
      best_score   <= '0;
      best_idx     <= '0;
      ptr          <= '0;
      out_class    <= '0;
      out_score    <= '0;
      out_all_zero <= 1'b0;
      frame_cnt    <= '0;
    end else if (accept) begin
      for (int k = 0; k < NUM_CLASSES; k++) lanes[k] <= in_data[k*DW +: DW];
      best_score <= in_data[DW-1:0];
      best_idx   <= '0;
      ptr        <= FIRST_PTR;
      if (frame_cnt != '1) frame_cnt <= frame_cnt + CNTW'(1);
      if (NUM_CLASSES == 1) begin
        out_class    <= '0;
        out_score    <= in_data[DW-1:0];
        out_all_zero <= (in_data[DW-1:0] == '0);
      end
    end else if (state == SCAN) begin
      best_score <= scan_score;
      best_idx   <= scan_idx;
      if (last_lane) begin
        out_class    <= scan_idx;
        out_score    <= scan_score;
        out_all_zero <= (scan_score == '0);
      end else begin
        ptr <= ptr + IDXW'(1);
      end
    end
  end

endmodule

// File: tb/tb_relu_layer_argmax.sv
// Directed and table-driven bench for relu_layer_argmax at its default 4x8-bit configuration.
module tb_relu_layer_argmax;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_class;
  logic [7:0]  out_score;
  logic        out_all_zero;
  logic [15:0] frame_cnt;

  int checks = 0;
  int errors = 0;

  relu_layer_argmax #(.NUM_CLASSES(4), .DW(8), .IDXW(2), .CNTW(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
    .out_score(out_score), .out_all_zero(out_all_zero), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  cls;
    logic [7:0]  score;
    logic        zero;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pack4(input int l0, input int l1, input int l2, input int l3);
    return {8'(l3), 8'(l2), 8'(l1), 8'(l0)};
  endfunction

  function automatic void ref_argmax(input logic [31:0] d, output logic [1:0] c,
                                     output logic [7:0] s);
    logic [7:0] lane;
    c = 2'd0;
    s = d[7:0];
    for (int k = 1; k < 4; k++) begin
      lane = d[k*8 +: 8];
      if (lane > s) begin
        s = lane;
        c = 2'(k);
      end
    end
  endfunction

  // Offers one frame from IDLE with out_ready=1 and checks the full result transaction.
  task automatic send_frame(input string name, input logic [31:0] d, input logic [1:0] cls,
                            input logic [7:0] score, input logic zero, input int cnt);
    int lat;
    check({name, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({name, "_latency"}, 32'(lat), 32'd3);
    check({name, "_class"}, 32'(out_class), 32'(cls));
    check({name, "_score"}, 32'(out_score), 32'(score));
    check({name, "_all_zero"}, 32'(out_all_zero), 32'(zero));
    check({name, "_frame_cnt"}, 32'(frame_cnt), 32'(cnt));
    tick();
    check({name, "_valid_drop"}, 32'(out_valid), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    vec_t vecs[6];
    logic [31:0] frames[10];
    logic [1:0]  exp_c;
    logic [7:0]  exp_s;
    int          acc_cyc[10];
    int          sent, got, cyc;
    bit          saw_valid;
    int          lat;

    vecs[0] = '{pack4(12, 87, 40, 5),     2'd1, 8'd87,  1'b0};
    vecs[1] = '{pack4(30, 90, 90, 90),    2'd1, 8'd90,  1'b0};
    vecs[2] = '{pack4(0, 0, 0, 0),        2'd0, 8'd0,   1'b1};
    vecs[3] = '{pack4(200, 3, 200, 255),  2'd3, 8'd255, 1'b0};
    vecs[4] = '{pack4(0, 0, 0, 1),        2'd3, 8'd1,   1'b0};
    vecs[5] = '{pack4(127, 128, 128, 64), 2'd1, 8'd128, 1'b0};

    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    do_reset();
    repeat (5) tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_class", 32'(out_class), 32'd0);
    check("rst_score", 32'(out_score), 32'd0);
    check("rst_all_zero", 32'(out_all_zero), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);

    for (int i = 0; i < 6; i++)
      send_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].cls, vecs[i].score,
                 vecs[i].zero, i + 1);

    // Backpressure: result held while a second frame is offered continuously.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = pack4(5, 6, 7, 8);
    tick();
    in_data   = pack4(50, 1, 1, 1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    for (int i = 0; i < 6; i++) begin
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_class", 32'(out_class), 32'd3);
      check("bp_score", 32'(out_score), 32'd8);
      check("bp_frame_cnt", 32'(frame_cnt), 32'd7);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_keep_score", 32'(out_score), 32'd8);
    tick();
    in_valid = 1'b0;
    check("bp_second_taken", 32'(frame_cnt), 32'd8);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("bp_second_class", 32'(out_class), 32'd0);
    check("bp_second_score", 32'(out_score), 32'd50);
    tick();

    // Reset one cycle after accept aborts the frame.
    in_valid = 1'b1;
    in_data  = pack4(1, 2, 3, 200);
    tick();
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_class", 32'(out_class), 32'd0);
    check("abort_score", 32'(out_score), 32'd0);
    check("abort_all_zero", 32'(out_all_zero), 32'd0);
    check("abort_frame_cnt", 32'(frame_cnt), 32'd0);
    saw_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) saw_valid = 1'b1;
      tick();
    end
    check("abort_no_valid", 32'(saw_valid), 32'd0);
    send_frame("post_abort", pack4(9, 0, 0, 0), 2'd0, 8'd9, 1'b0, 1);

    // Back-to-back frames; a few lanes drawn from a small range to provoke ties.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      frames[i] = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 3)),
                   8'($urandom_range(0, 255)), 8'($urandom_range(0, 3))};
      if (i == 4) frames[i] = '0;
    end
    sent = 0;
    got  = 0;
    cyc  = 0;
    while (got < 10 && cyc < 200) begin
      if (out_valid) begin
        ref_argmax(frames[got], exp_c, exp_s);
        check($sformatf("rnd%0d_class", got), 32'(out_class), 32'(exp_c));
        check($sformatf("rnd%0d_score", got), 32'(out_score), 32'(exp_s));
        check($sformatf("rnd%0d_all_zero", got), 32'(out_all_zero), 32'(exp_s == 8'd0));
        got++;
      end
      if (in_ready && sent < 10) begin
        in_valid = 1'b1;
        in_data  = frames[sent];
        acc_cyc[sent] = cyc;
        sent++;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    check("rnd_results", 32'(got), 32'd10);
    check("rnd_frame_cnt", 32'(frame_cnt), 32'd10);
    for (int i = 1; i < sent; i++)
      check($sformatf("rnd%0d_interval", i), 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
